ensemble_diag_scheduler: RTL and testbench

//  Top-level sequencer for one bin-ratio ensemble inference. Per accepted spectrum it runs
//  NUM_DIAG passes, one per diagonal sub-network. Each pass starts the preprocessing state

---
 rtl/ensemble_diag_scheduler_pkg.sv | 20 ++
 rtl/ensemble_diag_scheduler_watchdog.sv | 24 ++
 rtl/ensemble_diag_scheduler.sv | 125 ++++++++++++
 tb/tb_ensemble_diag_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ensemble_diag_scheduler_pkg.sv
// Shared scheduler definitions: state encoding and default ensemble geometry,
// also used by the prepro and SNN control blocks.
package ensemble_diag_scheduler_pkg;

    localparam int NUM_DIAG_DEF    = 20;
    localparam int DIAG_W_DEF      = 5;
    localparam int TIMEOUT_CYC_DEF = 2048;
    localparam int TO_W_DEF        = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_START = 3'd1,
        ST_PRE_WAIT  = 3'd2,
        ST_SNN_START = 3'd3,
        ST_SNN_WAIT  = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } sched_state_e;

endpackage

// File: rtl/ensemble_diag_scheduler_watchdog.sv
// sched_watchdog: cycle counter that flags expiry on the last allowed wait cycle.
module sched_watchdog
    import ensemble_diag_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)      r_cnt <= '0;
        else if (i_clear)  r_cnt <= '0;
        else if (i_enable) r_cnt <= r_cnt + 1'b1;
    end

    // The owner leaves the wait state on expiry, so the counter never wraps.
    assign o_expire = i_enable && (r_cnt == TO_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/ensemble_diag_scheduler.sv
// Per-spectrum sequencer: NUM_DIAG prepro->SNN passes, one per ensemble diagonal.
// Define SCHED_WATCHDOG_EN to add the per-wait-state watchdog and sticky timeout_err.
module ensemble_diag_scheduler
    import ensemble_diag_scheduler_pkg::*;
#(
    parameter int NUM_DIAG    = NUM_DIAG_DEF,
    parameter int DIAG_W      = DIAG_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_spec_valid,
    output logic              o_spec_ready,
    input  logic              i_abort,
    output logic              o_prepro_start,
    input  logic              i_prepro_finished,
    output logic              o_snn_start,
    input  logic              i_snn_done,
    output logic [DIAG_W-1:0] o_diag_idx,
    output logic              o_busy,
    output logic              o_all_done,
    output logic              o_timeout_err
);
    sched_state_e      r_state, w_state_nxt;
    logic [DIAG_W-1:0] r_diag, w_diag_nxt;
    logic              w_last;

    if (NUM_DIAG < 1 || (2 ** DIAG_W) < NUM_DIAG || (2 ** TO_W) <= TIMEOUT_CYC) begin : g_bad_cfg
        $error("ensemble_diag_scheduler: inconsistent NUM_DIAG/DIAG_W/TIMEOUT_CYC/TO_W");
    end

    assign w_last = (r_diag == DIAG_W'(NUM_DIAG - 1));

`ifdef SCHED_WATCHDOG_EN
    logic w_in_wait, w_expire, r_timeout_err;

    assign w_in_wait = (r_state == ST_PRE_WAIT) || (r_state == ST_SNN_WAIT);

    sched_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_wdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (!w_in_wait),
        .i_enable (w_in_wait),
        .o_expire (w_expire)
    );

    // ERR is only left via abort/reset, so the flag simply tracks ERR residency.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_timeout_err <= 1'b0;
        else          r_timeout_err <= (w_state_nxt == ST_ERR);
    end
    assign o_timeout_err = r_timeout_err;
`else
    assign o_timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_diag_nxt  = r_diag;
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_diag_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_spec_valid && !i_abort) begin
                        w_state_nxt = ST_PRE_START;
                        w_diag_nxt  = '0;
                    end
                end
                ST_PRE_START: w_state_nxt = ST_PRE_WAIT;
                ST_PRE_WAIT: begin
                    if (i_prepro_finished) w_state_nxt = ST_SNN_START;
`ifdef SCHED_WATCHDOG_EN
                    else if (w_expire)     w_state_nxt = ST_ERR;
`endif
                end
                ST_SNN_START: w_state_nxt = ST_SNN_WAIT;
                ST_SNN_WAIT: begin
                    if (i_snn_done) begin
                        if (w_last) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_PRE_START;
                            w_diag_nxt  = r_diag + 1'b1;
                        end
                    end
`ifdef SCHED_WATCHDOG_EN
                    else if (w_expire) w_state_nxt = ST_ERR;
`endif
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_diag_nxt  = '0;
                end
                ST_ERR:  w_state_nxt = ST_ERR;
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_diag_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_diag  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_diag  <= w_diag_nxt;
        end
    end

    assign o_spec_ready   = (r_state == ST_IDLE);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_prepro_start = (r_state == ST_PRE_START);
    assign o_snn_start    = (r_state == ST_SNN_START);
    assign o_all_done     = (r_state == ST_DONE);
    assign o_diag_idx     = r_diag;
endmodule

// File: tb/tb_ensemble_diag_scheduler.sv
// Bench for ensemble_diag_scheduler: vector table, directed corner sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_ensemble_diag_scheduler;
    localparam int ND = 3;
    localparam int DW = 2;
    localparam int TO = 16;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n, spec_valid, abort, fin, sdone;
    logic          spec_ready, pstart, sstart, busy, all_done, terr;
    logic [DW-1:0] diag;

    always #5 clk = ~clk;

    ensemble_diag_scheduler #(
        .NUM_DIAG(ND), .DIAG_W(DW), .TIMEOUT_CYC(TO), .TO_W(TW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_spec_valid(spec_valid), .o_spec_ready(spec_ready),
        .i_abort(abort), .o_prepro_start(pstart), .i_prepro_finished(fin),
        .o_snn_start(sstart), .i_snn_done(sdone), .o_diag_idx(diag), .o_busy(busy),
        .o_all_done(all_done), .o_timeout_err(terr)
    );

    int vecs = 0;
    int errs = 0;

    typedef struct packed {
        logic v, a, f, d;
        logic rdy, bsy, ps, ss;
        logic [1:0] dg;
        logic ad;
    } vec_t;
    vec_t tbl [30];

    function automatic logic [7:0] obs();
        return {spec_ready, busy, pstart, sstart, diag, all_done, terr};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic a, input logic f, input logic d);
        spec_valid = v; abort = a; fin = f; sdone = d;
    endtask

    // reference model state
    bit m_busy, m_err;
    int m_pass, m_wait, m_strobe, m_wcnt;   // wait: 0 none/1 prepro/2 snn; strobe: 0/1 pre/2 snn/3 done

    function automatic bit wd_on();
`ifdef SCHED_WATCHDOG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input bit v, input bit a, input bit f, input bit d);
        if (a && m_busy) begin
            m_busy = 0; m_err = 0; m_pass = 0; m_wait = 0; m_strobe = 0;
        end else if (!m_busy) begin
            if (v && !a) begin m_busy = 1; m_pass = 0; m_strobe = 1; end
        end else if (m_err) begin
        end else if (m_strobe == 1) begin
            m_strobe = 0; m_wait = 1; m_wcnt = 0;
        end else if (m_strobe == 2) begin
            m_strobe = 0; m_wait = 2; m_wcnt = 0;
        end else if (m_strobe == 3) begin
            m_busy = 0; m_strobe = 0; m_pass = 0;
        end else begin
            if ((m_wait == 1 && f) || (m_wait == 2 && d)) begin
                if (m_wait == 1) m_strobe = 2;
                else if (m_pass == ND - 1) m_strobe = 3;
                else begin m_pass++; m_strobe = 1; end
                m_wait = 0;
            end else if (wd_on() && m_wcnt == TO - 1) begin
                m_err = 1; m_wait = 0;
            end else m_wcnt++;
        end
    endtask

    int pl, sl, np, ns, nad, fin_at, done_at, last_done, ad_cyc, acc2_cyc, nacc;
    logic [7:0] exp_o;

    initial begin
        tbl[0]  = 11'b1000_1000_00_0;  tbl[1]  = 11'b0000_0110_00_0;
        tbl[2]  = 11'b0001_0100_00_0;  tbl[3]  = 11'b0010_0100_00_0;
        tbl[4]  = 11'b0010_0101_00_0;  tbl[5]  = 11'b0010_0100_00_0;
        tbl[6]  = 11'b0001_0100_00_0;  tbl[7]  = 11'b0000_0110_01_0;
        tbl[8]  = 11'b0010_0100_01_0;  tbl[9]  = 11'b0000_0101_01_0;
        tbl[10] = 11'b0001_0100_01_0;  tbl[11] = 11'b0000_0110_10_0;
        tbl[12] = 11'b0010_0100_10_0;  tbl[13] = 11'b0000_0101_10_0;
        tbl[14] = 11'b1001_0100_10_0;  tbl[15] = 11'b1000_0100_10_1;
        tbl[16] = 11'b1100_1000_00_0;  tbl[17] = 11'b1000_1000_00_0;
        tbl[18] = 11'b0100_0110_00_0;  tbl[19] = 11'b0000_1000_00_0;
        tbl[20] = 11'b1000_1000_00_0;  tbl[21] = 11'b0000_0110_00_0;
        tbl[22] = 11'b0010_0100_00_0;  tbl[23] = 11'b0000_0101_00_0;
        tbl[24] = 11'b0001_0100_00_0;  tbl[25] = 11'b0000_0110_01_0;
        tbl[26] = 11'b0010_0100_01_0;  tbl[27] = 11'b0000_0101_01_0;
        tbl[28] = 11'b0101_0100_01_0;  tbl[29] = 11'b0000_1000_00_0;

        // reset
        rst_n = 1'b0; drive(0, 0, 0, 0);
        step(); step();
        chk("reset_outputs", obs(), 8'b1000_00_0_0);
        rst_n = 1'b1;

        // table: each row checks the current outputs, then applies its inputs over one edge
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("table_row%0d", i), obs(),
                {tbl[i].rdy, tbl[i].bsy, tbl[i].ps, tbl[i].ss, tbl[i].dg, tbl[i].ad, 1'b0});
            drive(tbl[i].v, tbl[i].a, tbl[i].f, tbl[i].d);
            step();
        end
        drive(0, 0, 0, 0);
        step();

        // full run with long prepro latency
        pl = wd_on() ? 10 : 1025;
        sl = wd_on() ? 8 : 40;
        np = 0; ns = 0; nad = 0; fin_at = -1; done_at = -1; last_done = -100;
        spec_valid = 1'b1; step(); spec_valid = 1'b0;
        for (int c = 0; c < 8000 && nad == 0; c++) begin
            fin = (c == fin_at); sdone = (c == done_at);
            if (pstart) begin chk("full_pre_diag", diag, np); np++; fin_at = c + pl; end
            if (sstart) begin chk("full_snn_diag", diag, ns); ns++; done_at = c + sl; end
            if (all_done) begin nad++; chk("full_all_done_lat", c, last_done + 1); end
            if (terr) chk("full_no_timeout", terr, 0);
            if (sdone) last_done = c;
            step();
        end
        fin = 0; sdone = 0;
        chk("full_prepro_starts", np, ND);
        chk("full_snn_starts", ns, ND);
        chk("full_all_done_count", nad, 1);
        chk("full_ready_after", {spec_ready, busy}, 2'b10);

        // spec_valid held high: second acceptance only after all_done
        nacc = 0; ad_cyc = -1; acc2_cyc = -1; fin_at = -1; done_at = -1;
        spec_valid = 1'b1;
        for (int c = 0; c < 400 && acc2_cyc < 0; c++) begin
            fin = (c == fin_at); sdone = (c == done_at);
            if (pstart && diag == 0) begin nacc++; if (nacc == 2) acc2_cyc = c; end
            if (pstart) fin_at = c + 3;
            if (sstart) done_at = c + 2;
            if (all_done && ad_cyc < 0) ad_cyc = c;
            step();
        end
        chk("busy_drop_second_accept", acc2_cyc, ad_cyc + 2);
        drive(0, 1, 0, 0); step();
        drive(0, 0, 0, 0); step();
        chk("busy_drop_abort_idle", obs(), 8'b1000_00_0_0);

        // reset in the middle of a pass
        spec_valid = 1'b1; step(); spec_valid = 1'b0; step(); step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midpass_reset", obs(), 8'b1000_00_0_0);
        step();
        chk("midpass_reset_hold", obs(), 8'b1000_00_0_0);

`ifdef SCHED_WATCHDOG_EN
        // no prepro_finished: 16 PRE_WAIT cycles then ERR
        spec_valid = 1'b1; step(); spec_valid = 1'b0; step();
        for (int i = 0; i < 15; i++) step();
        chk("wd_before_limit", obs(), 8'b0100_00_0_0);
        step();
        chk("wd_err_entry", obs(), 8'b0100_00_0_1);
        for (int i = 0; i < 5; i++) begin drive(1, 0, 1, 1); step(); end
        drive(0, 0, 0, 0);
        chk("wd_err_sticky", obs(), 8'b0100_00_0_1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("wd_abort_clears", obs(), 8'b1000_00_0_0);
        // done pulses on the limit cycle take the normal path
        spec_valid = 1'b1; step(); spec_valid = 1'b0; step();
        for (int i = 0; i < 15; i++) step();
        fin = 1'b1; step(); fin = 1'b0;
        chk("wd_fin_on_limit", obs(), 8'b0101_00_0_0);
        step();
        for (int i = 0; i < 15; i++) step();
        sdone = 1'b1; step(); sdone = 1'b0;
        chk("wd_done_on_limit", obs(), 8'b0110_01_0_0);
        abort = 1'b1; step(); abort = 1'b0;
`else
        // without the watchdog a stalled prepro never errors out
        spec_valid = 1'b1; step(); spec_valid = 1'b0; step();
        for (int i = 0; i < 60; i++) step();
        chk("nowd_long_wait", obs(), 8'b0100_00_0_0);
        fin = 1'b1; step(); fin = 1'b0;
        chk("nowd_snn_start", obs(), 8'b0101_00_0_0);
        abort = 1'b1; step(); abort = 1'b0;
`endif
        chk("pre_random_idle", obs(), 8'b1000_00_0_0);

        // randomized run against the reference model
        m_busy = 0; m_err = 0; m_pass = 0; m_wait = 0; m_strobe = 0; m_wcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic v, a, f, d;
            exp_o = {!m_busy, m_busy, m_strobe == 1, m_strobe == 2, 2'(m_pass),
                     m_strobe == 3, m_err};
            chk($sformatf("random_cyc%0d", c), obs(), exp_o);
            v = ($urandom_range(2) == 0);
            a = ($urandom_range(49) == 0);
            f = (m_wait == 1) ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
            d = (m_wait == 2) ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
            drive(v, a, f, d);
            model_step(v, a, f, d);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
